mem_bus_if: RTL and testbench

Data-side bus interface between the CPU core's data-memory port (ram_* signals) and a Wishbone-style system bus. It converts each single-cycle CPU load/store request into a registered bus cycle. While the cycle is outstanding it raises a stall request to the control block, then returns load data to the MEM stage. It also holds returned data across pipeline stalls and aborts on pipeline flush.

---
 rtl/mem_bus_if_if.sv | 26 ++
 rtl/mem_bus_if.sv | 136 +++++++++++++
 tb/tb_mem_bus_if.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if_if.sv
// Wishbone-style data bus bundle between the CPU data-side bridge (master)
// and the system bus (slave).
interface mem_bus_if_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4
) ();
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          we_o;
  logic [SW-1:0] sel_o;
  logic          stb_o;
  logic          cyc_o;
  logic [DW-1:0] data_i;
  logic          ack_i;

  modport master (
    output addr_o, data_o, we_o, sel_o, stb_o, cyc_o,
    input  data_i, ack_i
  );

  modport slave (
    input  addr_o, data_o, we_o, sel_o, stb_o, cyc_o,
    output data_i, ack_i
  );
endinterface

// File: rtl/mem_bus_if.sv
// Turns single-cycle CPU load/store requests into registered Wishbone cycles,
// stalls the pipeline while a cycle is outstanding and holds load data across stalls.
module mem_bus_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall_i,
  input  logic          flush_i,
  input  logic          cpu_ce_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  input  logic          cpu_we_i,
  input  logic [SW-1:0] cpu_sel_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          stallreq_o,
  mem_bus_if_if.master  wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          act_q, act_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;

  // State and bus registers; stb and cyc share one activity flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= {AW{1'b0}};
      data_q   <= {DW{1'b0}};
      we_q     <= 1'b0;
      sel_q    <= {SW{1'b0}};
      act_q    <= 1'b0;
      rd_buf_q <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      act_q    <= act_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // Next-state, bus capture/clear and the combinational stall/data returns.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    sel_d      = sel_q;
    act_d      = act_q;
    rd_buf_d   = rd_buf_q;
    stallreq_o = 1'b0;
    cpu_data_o = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          act_d   = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Flush wins over a simultaneous ack: the returned word is discarded.
        if (flush_i) begin
          addr_d   = {AW{1'b0}};
          data_d   = {DW{1'b0}};
          we_d     = 1'b0;
          sel_d    = {SW{1'b0}};
          act_d    = 1'b0;
          rd_buf_d = {DW{1'b0}};
          state_d  = ST_IDLE;
        end else if (wb.ack_i) begin
          cpu_data_o = wb.data_i;
          addr_d     = {AW{1'b0}};
          data_d     = {DW{1'b0}};
          we_d       = 1'b0;
          sel_d      = {SW{1'b0}};
          act_d      = 1'b0;
          rd_buf_d   = wb.data_i;
          state_d    = (stall_i != 6'd0) ? ST_HOLD : ST_IDLE;
        end else begin
          stallreq_o = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_HOLD: begin
        cpu_data_o = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = {DW{1'b0}};
          state_d  = ST_IDLE;
        end else if (stall_i == 6'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        addr_d   = {AW{1'b0}};
        data_d   = {DW{1'b0}};
        we_d     = 1'b0;
        sel_d    = {SW{1'b0}};
        act_d    = 1'b0;
        rd_buf_d = {DW{1'b0}};
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign wb.addr_o = addr_q;
  assign wb.data_o = data_q;
  assign wb.we_o   = we_q;
  assign wb.sel_o  = sel_q;
  assign wb.stb_o  = act_q;
  assign wb.cyc_o  = act_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed and randomized checks of mem_bus_if against a cycle-level
// behavioural model of an outstanding access and a held read word.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] cpu_data;
  logic        stallreq;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: an outstanding access (with its captured request) or a held word.
  bit          m_out;
  bit          m_held;
  logic [31:0] m_addr, m_data, m_buf;
  logic        m_we;
  logic [3:0]  m_sel;

  mem_bus_if_if #(.DW(32), .AW(32), .SW(4)) bus ();

  mem_bus_if #(.DW(32), .AW(32), .SW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_ce_i   (ce),
    .cpu_addr_i (addr),
    .cpu_data_i (wdata),
    .cpu_we_i   (we),
    .cpu_sel_i  (sel),
    .cpu_data_o (cpu_data),
    .stallreq_o (stallreq),
    .wb         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_model();
    m_out  = 1'b0;
    m_held = 1'b0;
    m_buf  = 32'h0;
  endtask

  // Called after inputs are driven at the falling edge; checks, advances the model, waits a cycle.
  task automatic tick();
    logic        e_stall;
    logic [31:0] e_rd;
    #1;
    e_stall = 1'b0;
    e_rd    = 32'h0;
    if (m_out) begin
      e_stall = !flush && !bus.ack_i;
      if (bus.ack_i && !flush) e_rd = bus.data_i;
    end else if (m_held) begin
      e_rd = m_buf;
    end else begin
      e_stall = ce && !flush;
    end
    chk("stallreq", {63'd0, stallreq}, {63'd0, e_stall});
    chk("cpu_data", {32'd0, cpu_data}, {32'd0, e_rd});
    chk("wb_addr",  {32'd0, bus.addr_o}, {32'd0, m_out ? m_addr : 32'h0});
    chk("wb_data",  {32'd0, bus.data_o}, {32'd0, m_out ? m_data : 32'h0});
    chk("wb_we",    {63'd0, bus.we_o},   {63'd0, m_out ? m_we : 1'b0});
    chk("wb_sel",   {60'd0, bus.sel_o},  {60'd0, m_out ? m_sel : 4'h0});
    chk("wb_stb",   {63'd0, bus.stb_o},  {63'd0, m_out});
    chk("wb_cyc",   {63'd0, bus.cyc_o},  {63'd0, m_out});
    if (rst) begin
      drop_model();
    end else if (m_out) begin
      if (flush) begin
        drop_model();
      end else if (bus.ack_i) begin
        m_out  = 1'b0;
        m_buf  = bus.data_i;
        m_held = (stall != 6'd0);
      end
    end else if (m_held) begin
      if (flush) drop_model();
      else if (stall == 6'd0) m_held = 1'b0;
    end else if (ce && !flush) begin
      m_out  = 1'b1;
      m_addr = addr;
      m_data = wdata;
      m_we   = we;
      m_sel  = sel;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce    = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sel   = s;
  endtask

  task automatic idle_in();
    ce        = 1'b0;
    we        = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    sel       = 4'h0;
    bus.ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0;
    bus.data_i = 32'h0;
    idle_in();
    drop_model();
    m_addr = 32'h0; m_data = 32'h0; m_we = 1'b0; m_sel = 4'h0;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Load acked in the first BUSY cycle.
    req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    #1 chk("ld_req_stall", {63'd0, stallreq}, 64'd1);
    tick();
    idle_in();
    bus.ack_i = 1'b1; bus.data_i = 32'hDEAD_BEEF;
    #1 chk("ld_ack_data", {32'd0, cpu_data}, 64'hDEAD_BEEF);
    chk("ld_addr", {32'd0, bus.addr_o}, 64'h10);
    tick();
    bus.ack_i = 1'b0;
    #1 chk("ld_stb_done", {63'd0, bus.stb_o}, 64'd0);
    tick();

    // Store with three wait cycles.
    req(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1 chk("st_wait_data", {32'd0, bus.data_o}, 64'h1234_5678);
      chk("st_wait_stall", {63'd0, stallreq}, 64'd1);
      tick();
    end
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    #1 chk("st_cleared", {63'd0, bus.cyc_o}, 64'd0);
    tick();

    // Ack while the pipeline is stalled: data held in HOLD.
    req(1'b0, 32'h0000_0044, 32'h0, 4'hF);
    tick();
    idle_in();
    bus.ack_i = 1'b1; bus.data_i = 32'hCAFE_0001; stall = 6'b001111;
    tick();
    bus.ack_i = 1'b0; bus.data_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_data", {32'd0, cpu_data}, 64'hCAFE_0001);
      tick();
    end
    stall = 6'd0;
    tick();
    #1 chk("hold_exit", {32'd0, cpu_data}, 64'h0);
    tick();

    // Flush with a simultaneous ack in the second BUSY cycle.
    req(1'b0, 32'h0000_0050, 32'h0, 4'hF);
    tick();
    idle_in();
    tick();
    flush = 1'b1; bus.ack_i = 1'b1; bus.data_i = 32'h5555_AAAA; stall = 6'b000011;
    #1 chk("flush_data", {32'd0, cpu_data}, 64'h0);
    chk("flush_stall", {63'd0, stallreq}, 64'd0);
    tick();
    flush = 1'b0; bus.ack_i = 1'b0;
    #1 chk("flush_no_hold", {32'd0, cpu_data}, 64'h0);
    chk("flush_stb", {63'd0, bus.stb_o}, 64'd0);
    tick();
    stall = 6'd0;

    // Reset in the middle of an access, then a clean load.
    req(1'b1, 32'h0000_0060, 32'h0BAD_0BAD, 4'hC);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rst_stb", {63'd0, bus.stb_o}, 64'd0);
    chk("rst_stall", {63'd0, stallreq}, 64'd0);
    req(1'b0, 32'h0000_0070, 32'h0, 4'hF);
    tick();
    idle_in();
    bus.ack_i = 1'b1; bus.data_i = 32'h7777_0070;
    #1 chk("rst_after_data", {32'd0, cpu_data}, 64'h7777_0070);
    tick();

    // Back-to-back loads.
    req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    idle_in();
    bus.ack_i = 1'b1; bus.data_i = 32'h1111_0001;
    #1 chk("b2b_first", {32'd0, cpu_data}, 64'h1111_0001);
    tick();
    req(1'b0, 32'h0000_0104, 32'h0, 4'hF);
    tick();
    idle_in();
    #1 chk("b2b_second_addr", {32'd0, bus.addr_o}, 64'h104);
    bus.ack_i = 1'b1; bus.data_i = 32'h2222_0002;
    #1 chk("b2b_second", {32'd0, cpu_data}, 64'h2222_0002);
    tick();
    idle_in();
    tick();

    // Randomized traffic with stray acks, flushes, stalls and resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      ce         = $urandom_range(0, 1) == 1;
      we         = $urandom_range(0, 1) == 1;
      addr       = $urandom;
      wdata      = $urandom;
      sel        = 4'($urandom_range(0, 15));
      bus.ack_i  = ($urandom_range(0, 2) == 0);
      bus.data_i = $urandom;
      flush      = ($urandom_range(0, 11) == 0);
      stall      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
